fadd_operand_prep: RTL and testbench

- Pipelined upstream stage that feeds the single-precision FP adder.
- The adder requires: operand A magnitude >= operand B, same signs, no specials, and an exponent difference that is safe for the alignment shift.
- This block orders the operand pair by magnitude, classifies special cases, and computes a saturated exponent difference.
- Registered 2-stage pipeline with valid/ready handshakes on both sides, so it can sit between an operand source and the adder under backpressure.

---
 rtl/fp32_pkg.sv | 21 ++
 rtl/fp32_classify.sv | 22 ++
 rtl/fadd_operand_prep.sv | 132 +++++++++++++
 tb/tb_fadd_operand_prep.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Field positions, special-value encodings and flag indices for IEEE-754
// single precision, shared by the adder operand-preparation logic.
package fp32_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  // Bit positions inside out_flags = {nan, inf, zero_b, sign_mismatch}
  localparam int FLG_NAN = 3;
  localparam int FLG_INF = 2;
  localparam int FLG_ZB  = 1;
  localparam int FLG_SM  = 0;

  // A shift of 25 or more clears the 24-bit significand plus guard bit.
  localparam int DIFF_SAT_DEFAULT = 25;

endpackage

// File: rtl/fp32_classify.sv
// Per-operand decode of the exponent/fraction fields into special classes.
// Zero and denormals are both reported as zero; the sign is irrelevant here.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [EXP_MSB:0] op,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero
);

  logic exp_max;
  logic frac_nz;

  assign exp_max = (op[EXP_MSB:EXP_LSB] == EXP_ALL1);
  assign frac_nz = |op[FRAC_MSB:0];

  assign is_nan  = exp_max &  frac_nz;
  assign is_inf  = exp_max & ~frac_nz;
  assign is_zero = (op[EXP_MSB:EXP_LSB] == '0);

endmodule

// File: rtl/fadd_operand_prep.sv
// Two-stage operand preparation ahead of the FP adder: stage 1 orders the
// pair by magnitude, stage 2 classifies specials and computes the saturated
// exponent difference. Valid/ready on both sides; the only combinational
// path is out_ready -> in_ready.
module fadd_operand_prep
  import fp32_pkg::*;
#(
  parameter int DIFF_SAT = fp32_pkg::DIFF_SAT_DEFAULT,
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_a,
  output logic [EXP_W+FRAC_W:0]   out_b,
  output logic [EXP_W-1:0]        out_diff,
  output logic                    out_swapped,
  output logic [3:0]              out_flags
);

  localparam int OP_W = EXP_W + FRAC_W + 1;
  localparam logic [EXP_W:0]   SAT_WIDE = (EXP_W+1)'(DIFF_SAT);
  localparam logic [EXP_W-1:0] SAT_OUT  = EXP_W'(DIFF_SAT);

  logic            s1_valid;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;
  logic            s1_swapped;

  logic            s2_valid;
  logic [OP_W-1:0] s2_a;
  logic [OP_W-1:0] s2_b;
  logic [EXP_W-1:0] s2_diff;
  logic            s2_swapped;
  logic [3:0]      s2_flags;

  logic s1_adv;
  logic in_fire;
  logic swap;

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic [EXP_W:0]   diff_raw;
  logic [EXP_W-1:0] diff_nxt;
  logic [3:0]       flags_nxt;

  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // Magnitude compare on {exp, frac}; ties keep the original order.
  assign swap = (in_b[EXP_MSB:0] > in_a[EXP_MSB:0]);

  // Stage 1: capture the ordered pair on every accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_swapped <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_a       <= swap ? in_b : in_a;
      s1_b       <= swap ? in_a : in_b;
      s1_swapped <= swap;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  fp32_classify u_class_a (
    .op      (s1_a[EXP_MSB:0]),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero)
  );

  fp32_classify u_class_b (
    .op      (s1_b[EXP_MSB:0]),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero)
  );

  // Ordering guarantees exp(A) >= exp(B), so the 9-bit difference never wraps.
  // A zero A forces a zero B, so folding a_zero into zero_b changes nothing.
  always_comb begin
    diff_raw  = {1'b0, s1_a[EXP_MSB:EXP_LSB]} - {1'b0, s1_b[EXP_MSB:EXP_LSB]};
    diff_nxt  = (diff_raw >= SAT_WIDE) ? SAT_OUT : diff_raw[EXP_W-1:0];
    flags_nxt = '0;
    flags_nxt[FLG_NAN] = a_nan | b_nan;
    flags_nxt[FLG_INF] = ~(a_nan | b_nan) & (a_inf | b_inf);
    flags_nxt[FLG_ZB]  = b_zero | a_zero;
    flags_nxt[FLG_SM]  = s1_a[SIGN_BIT] ^ s1_b[SIGN_BIT];
  end

  // Stage 2: advance whenever the output slot is free or being drained;
  // payload is only refreshed when stage 1 actually holds a pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_a       <= '0;
      s2_b       <= '0;
      s2_diff    <= '0;
      s2_swapped <= 1'b0;
      s2_flags   <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a       <= s1_a;
        s2_b       <= s1_b;
        s2_diff    <= diff_nxt;
        s2_swapped <= s1_swapped;
        s2_flags   <= flags_nxt;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_a       = s2_a;
  assign out_b       = s2_b;
  assign out_diff    = s2_diff;
  assign out_swapped = s2_swapped;
  assign out_flags   = s2_flags;

endmodule

// File: tb/tb_fadd_operand_prep.sv
// Self-checking bench for fadd_operand_prep: directed cases with literal
// expectations, backpressure/reset sequences, then randomized traffic
// checked against an arithmetic reference model through an ordered queue.
module tb_fadd_operand_prep;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_diff;
  logic        out_swapped;
  logic [3:0]  out_flags;

  int compared   = 0;
  int mismatched = 0;

  logic [76:0] exp_q[$];
  bit          last_in_fire;
  bit          last_out_fire;
  bit          hold_chk;
  logic [76:0] held;

  fadd_operand_prep dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_diff    (out_diff),
    .out_swapped (out_swapped),
    .out_flags   (out_flags)
  );

  always #5 clk = ~clk;

  // Reference: order by magnitude, then classify from the ordered pair.
  function automatic logic [76:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb;
    logic [31:0] x, y;
    int ex, ey, fx, fy, d;
    bit sw, nan, inf, zb, sm;
    ma = longint'(a) % 64'h8000_0000;
    mb = longint'(b) % 64'h8000_0000;
    sw = (mb > ma);
    x  = sw ? b : a;
    y  = sw ? a : b;
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fx = int'(x[22:0]);   fy = int'(y[22:0]);
    d  = ex - ey;
    if (d > 25) d = 25;
    nan = (ex == 255 && fx != 0) || (ey == 255 && fy != 0);
    inf = !nan && ((ex == 255 && fx == 0) || (ey == 255 && fy == 0));
    zb  = (ey == 0);
    sm  = (x[31] != y[31]);
    return {x, y, 8'(d), sw, nan, inf, zb, sm};
  endfunction

  function automatic logic [76:0] bundle();
    return {out_a, out_b, out_diff, out_swapped, out_flags};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      1: r = {r[31], 8'hFF, 23'h0};
      2: r = {r[31], 8'hFF, r[22:1], 1'b1};
      3: r = {r[31], 8'h00, ($urandom_range(0, 1) == 0) ? 23'h0 : r[22:0]};
      4: r = {r[31], 8'($urandom_range(100, 150)), r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: observe handshakes mid-cycle, score, then step past the edge.
  task automatic tick();
    @(negedge clk);
    last_in_fire  = in_valid && in_ready;
    last_out_fire = out_valid && out_ready;
    if (hold_chk) check("stall_hold", {out_valid, bundle()}, {1'b1, held});
    hold_chk = out_valid && !out_ready;
    held     = bundle();
    if (last_out_fire) begin
      if (exp_q.size() == 0) check("spurious_out", 80'(out_valid), 80'(0));
      else check("out_pair", 80'(bundle()), 80'(exp_q.pop_front()));
    end
    if (last_in_fire) exp_q.push_back(model(in_a, in_b));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_in_fire) break;
    end
    if (!last_in_fire) check("send_timeout", 80'(in_ready), 80'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    check("drain_empty", 80'(exp_q.size()), 80'(0));
  endtask

  // Pair enters at edge E0; out_valid must be low after E0 and high after E0+1.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [76:0] expv);
    out_ready = 1'b1;
    send(a, b);
    check({tag, "_lat1"}, 80'(out_valid), 80'(0));
    tick();
    check({tag, "_lat2"}, 80'(out_valid), 80'(1));
    check(tag, 80'(bundle()), 80'(expv));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa [4];
    int outs;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    hold_chk = 0;
    #12;
    check("reset_outputs", {out_valid, bundle()}, 80'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("reset_in_ready", 80'(in_ready), 80'(1));
    check("reset_out_valid", 80'(out_valid), 80'(0));

    directed("order",    32'h3F800000, 32'h40000000, {32'h40000000, 32'h3F800000, 8'd1,  1'b1, 4'b0000});
    directed("diff24",   32'h4B800000, 32'h3F800000, {32'h4B800000, 32'h3F800000, 8'd24, 1'b0, 4'b0000});
    directed("diffsat",  32'h7F000000, 32'h3F800000, {32'h7F000000, 32'h3F800000, 8'd25, 1'b0, 4'b0000});
    directed("nan",      32'h7FC00000, 32'h3F800000, {32'h7FC00000, 32'h3F800000, 8'd25, 1'b0, 4'b1000});
    directed("inf_zero", 32'h7F800000, 32'h00000000, {32'h7F800000, 32'h00000000, 8'd25, 1'b0, 4'b0110});
    directed("eq_sign",  32'hBF800000, 32'h3F800000, {32'hBF800000, 32'h3F800000, 8'd0,  1'b0, 4'b0001});
    directed("nan_inf",  32'h7F800000, 32'hFFC00000, {32'hFFC00000, 32'h7F800000, 8'd0,  1'b1, 4'b1001});
    directed("denorm",   32'h3F800000, 32'h00400000, {32'h3F800000, 32'h00400000, 8'd25, 1'b0, 4'b0010});

    // Backpressure: two pairs fill the pipe, the third is refused.
    pa[0] = 32'h40400000; pa[1] = 32'hC0A00000; pa[2] = 32'h3E000000; pa[3] = 32'h41200000;
    out_ready = 1'b0;
    in_b = 32'h3F000000; in_valid = 1'b1;
    outs = 0;
    for (int t = 0; t < 20 && outs < 2; t++) begin
      in_a = pa[outs];
      tick();
      if (last_in_fire) outs++;
    end
    in_a = pa[2];
    tick();
    check("bp_refused", 80'(last_in_fire), 80'(0));
    check("bp_in_ready", 80'(in_ready), 80'(0));
    out_ready = 1'b1;
    #1;
    check("simul_in_ready", 80'(in_ready), 80'(1));
    outs = 0;
    tick();
    check("simul_fire", 80'({last_in_fire, last_out_fire}), 80'(2'b11));
    outs += int'(last_out_fire);
    in_a = pa[3];
    tick();
    check("simul_fire2", 80'({last_in_fire, last_out_fire}), 80'(2'b11));
    outs += int'(last_out_fire);
    in_valid = 1'b0;
    tick(); outs += int'(last_out_fire);
    tick(); outs += int'(last_out_fire);
    check("bp_out_count", 80'(outs), 80'(4));
    check("bp_queue", 80'(exp_q.size()), 80'(0));

    // Steady-state throughput: 8 back-to-back pairs, one per cycle.
    out_ready = 1'b1; in_valid = 1'b1; outs = 0;
    for (int i = 0; i < 8; i++) begin
      in_a = rand_op(); in_b = rand_op();
      tick();
      outs += int'(last_in_fire);
    end
    in_valid = 1'b0;
    check("throughput", 80'(outs), 80'(8));
    drain();

    // Asynchronous reset with two pairs in flight.
    out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000);
    send(32'h42000000, 32'hC2000000);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {out_valid, bundle()}, 80'(0));
    exp_q.delete();
    hold_chk = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("rst_mid_in_ready", 80'(in_ready), 80'(1));
    check("rst_mid_no_replay", 80'(out_valid), 80'(0));
    directed("post_rst", 32'h3F800000, 32'h40000000, {32'h40000000, 32'h3F800000, 8'd1, 1'b1, 4'b0000});

    // Randomized traffic with random backpressure; inputs held until accepted.
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = rand_op();
        case ($urandom_range(0, 3))
          0: in_b = in_a ^ 32'h8000_0000;
          1: in_b = {in_a[31:23] + 9'($urandom_range(0, 3)), 23'($urandom)};
          default: in_b = rand_op();
        endcase
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
